// File: rtl/axi4lite_apb_frontend.sv
// AXI4-Lite slave front end of the AXI4-Lite-to-APB bridge: holds AW/W/AR, arbitrates, decodes the slave and
// drives the APB master request interface. Optional WSTRB checking is enabled by defining AXI2APB_STRB_CHK_EN.
module axi4lite_apb_frontend #(
    parameter int C_APB_NUM_SLAVES = 1,
    parameter int C_ADDR_SEL_LSB   = 12
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [31:0] AWADDR,
    input  logic        WVALID,
    output logic        WREADY,
    input  logic [31:0] WDATA,
    input  logic [3:0]  WSTRB,
    output logic        BVALID,
    input  logic        BREADY,
    output logic [1:0]  BRESP,
    input  logic        ARVALID,
    output logic        ARREADY,
    input  logic [31:0] ARADDR,
    output logic        RVALID,
    input  logic        RREADY,
    output logic [31:0] RDATA,
    output logic [1:0]  RRESP,
    output logic        STREQ,
    output logic        SWRT,
    output logic        SSEL,
    output logic [31:0] SADDR,
    output logic [31:0] SWDATA,
    output logic [3:0]  SLV_IDX,
    input  logic [31:0] SRDATA,
    input  logic [1:0]  APB_STATE,
    input  logic        PREADY,
    input  logic        PSLVERR,
    output logic [2:0]  dbg_state
);

    // Handshakes: a beat transfers on a rising PCLK edge where VALID and READY are both high; VALID, once
    // raised, is held with its payload stable until that edge.
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_BRESP, S_RRESP} state_t;

    localparam logic [4:0] NUM_SLV = 5'(C_APB_NUM_SLAVES);
    localparam logic [1:0] APB_SETUP  = 2'd1;
    localparam logic [1:0] APB_ACCESS = 2'd2;

    state_t      state, state_d;
    logic        aw_held, w_held, ar_held;
    logic [31:0] aw_addr, w_data, ar_addr;
    logic        last_rd;
    logic [1:0]  resp_q;
    logic [3:0]  wr_idx, rd_idx;
    logic        wr_dec_err, rd_dec_err, strb_err;
    logic        wr_go, rd_go, pick_wr, pick_rd;
    logic        take_wr, take_rd, setup_seen, xfer_done;

`ifdef AXI2APB_STRB_CHK_EN
    logic [3:0]  w_strb;
    assign strb_err = (w_strb != 4'hF);
`else
    logic        strb_unused;
    assign strb_unused = ^WSTRB;
    assign strb_err    = 1'b0;
`endif

    assign AWREADY = PRESETn & ~aw_held;
    assign WREADY  = PRESETn & ~w_held;
    assign ARREADY = PRESETn & ~ar_held;

    assign wr_idx     = aw_addr[C_ADDR_SEL_LSB +: 4];
    assign rd_idx     = ar_addr[C_ADDR_SEL_LSB +: 4];
    assign wr_dec_err = ({1'b0, wr_idx} >= NUM_SLV);
    assign rd_dec_err = ({1'b0, rd_idx} >= NUM_SLV);

    // When both directions are ready, the one not served last goes first.
    assign wr_go   = aw_held & w_held;
    assign rd_go   = ar_held;
    assign pick_wr = wr_go & (~rd_go | last_rd);
    assign pick_rd = rd_go & ~pick_wr;

    assign BVALID    = (state == S_BRESP);
    assign RVALID    = (state == S_RRESP);
    assign BRESP     = resp_q;
    assign RRESP     = resp_q;
    assign dbg_state = state;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= S_IDLE;
        else          state <= state_d;
    end

    always_comb begin
        state_d    = state;
        take_wr    = 1'b0;
        take_rd    = 1'b0;
        setup_seen = 1'b0;
        xfer_done  = 1'b0;
        case (state)
            S_IDLE: begin
                if (pick_wr) begin
                    take_wr = 1'b1;
                    state_d = (wr_dec_err || strb_err) ? S_BRESP : S_ISSUE;
                end else if (pick_rd) begin
                    take_rd = 1'b1;
                    state_d = rd_dec_err ? S_RRESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (APB_STATE == APB_SETUP) begin
                    setup_seen = 1'b1;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (APB_STATE == APB_ACCESS && PREADY) begin
                    xfer_done = 1'b1;
                    state_d   = SWRT ? S_BRESP : S_RRESP;
                end
            end
            S_BRESP: if (BREADY) state_d = S_IDLE;
            S_RRESP: if (RREADY) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            ar_held <= 1'b0;
            aw_addr <= '0;
            w_data  <= '0;
            ar_addr <= '0;
`ifdef AXI2APB_STRB_CHK_EN
            w_strb  <= '0;
`endif
            last_rd <= 1'b1;
            resp_q  <= 2'b00;
            RDATA   <= '0;
            STREQ   <= 1'b0;
            SSEL    <= 1'b0;
            SWRT    <= 1'b0;
            SADDR   <= '0;
            SWDATA  <= '0;
            SLV_IDX <= '0;
        end else begin
            // Holders refill while a transfer is in flight so the next request is already waiting.
            if (take_wr) begin
                aw_held <= 1'b0;
            end else if (AWVALID && AWREADY) begin
                aw_held <= 1'b1;
                aw_addr <= AWADDR;
            end
            if (take_wr) begin
                w_held <= 1'b0;
            end else if (WVALID && WREADY) begin
                w_held <= 1'b1;
                w_data <= WDATA;
`ifdef AXI2APB_STRB_CHK_EN
                w_strb <= WSTRB;
`endif
            end
            if (take_rd) begin
                ar_held <= 1'b0;
            end else if (ARVALID && ARREADY) begin
                ar_held <= 1'b1;
                ar_addr <= ARADDR;
            end

            if (take_wr) begin
                last_rd <= 1'b0;
                if (wr_dec_err) begin
                    resp_q <= 2'b11;
                end else if (strb_err) begin
                    resp_q <= 2'b10;
                end else begin
                    SADDR   <= aw_addr;
                    SWDATA  <= w_data;
                    SWRT    <= 1'b1;
                    SLV_IDX <= wr_idx;
                    STREQ   <= 1'b1;
                    SSEL    <= 1'b1;
                end
            end
            if (take_rd) begin
                last_rd <= 1'b1;
                if (rd_dec_err) begin
                    resp_q <= 2'b11;
                    RDATA  <= '0;
                end else begin
                    SADDR   <= ar_addr;
                    SWRT    <= 1'b0;
                    SLV_IDX <= rd_idx;
                    STREQ   <= 1'b1;
                    SSEL    <= 1'b1;
                end
            end
            // Dropping STREQ once Setup is seen keeps the master from chaining a second transfer.
            if (setup_seen) STREQ <= 1'b0;
            if (xfer_done) begin
                resp_q <= PSLVERR ? 2'b10 : 2'b00;
                SSEL   <= 1'b0;
                if (!SWRT) RDATA <= SRDATA;
            end
        end
    end

endmodule

// File: tb/tb_axi4lite_apb_frontend.sv
// Bench for axi4lite_apb_frontend: APB master model plus scoreboards for APB requests and B/R responses.
module tb_axi4lite_apb_frontend;

    localparam int         NUM_SLV = 2;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd2;

    logic        PCLK, PRESETn;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;
    logic        STREQ, SWRT, SSEL, PREADY, PSLVERR;
    logic [31:0] SADDR, SWDATA, SRDATA;
    logic [3:0]  SLV_IDX;
    logic [1:0]  APB_STATE;
    logic [2:0]  dbg_state;

    logic [68:0] exp_apb_q[$];
    logic [1:0]  exp_b_q[$];
    logic [33:0] exp_r_q[$];
    int          hs_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int n_xfer = 0;
    int cyc = 0;
    int streq_in_access = 0;
    int apb_waits = 0;
    bit apb_err = 1'b0;
    int wcnt = 0;
    bit streq_s = 1'b0;
    int x0;

    axi4lite_apb_frontend #(.C_APB_NUM_SLAVES(NUM_SLV), .C_ADDR_SEL_LSB(12)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .STREQ(STREQ), .SWRT(SWRT), .SSEL(SSEL), .SADDR(SADDR), .SWDATA(SWDATA),
        .SLV_IDX(SLV_IDX), .SRDATA(SRDATA), .APB_STATE(APB_STATE),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .dbg_state(dbg_state)
    );

    // Clock and cycle counter
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return (a == 32'h4) ? 32'h1234_5678 : ~a;
    endfunction

    task automatic set_cpl(input bit rdy);
        PREADY  = rdy;
        PSLVERR = rdy && apb_err;
        SRDATA  = rdy ? rdata_of(SADDR) : 32'h0;
    endtask

    // APB master model and monitors; everything runs on the falling edge so the DUT samples stable inputs.
    initial begin
        APB_STATE = 2'd0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        SRDATA    = 32'h0;
        forever begin
            @(negedge PCLK);
            if (!PRESETn) begin
                APB_STATE = 2'd0;
                set_cpl(1'b0);
                streq_s = 1'b0;
                continue;
            end
            if (BVALID && BREADY) begin
                hs_q.push_back(cyc);
                if (exp_b_q.size() == 0) check("b_unexpected", 1, 0);
                else check("bresp", BRESP, exp_b_q.pop_front());
            end
            if (RVALID && RREADY) begin
                hs_q.push_back(cyc);
                if (exp_r_q.size() == 0) check("r_unexpected", 1, 0);
                else check("rresp_rdata", {RRESP, RDATA}, exp_r_q.pop_front());
            end
            if (STREQ && APB_STATE == 2'd2) streq_in_access++;
            case (APB_STATE)
                2'd0: if (streq_s) begin
                    APB_STATE = 2'd1;
                    n_xfer++;
                    if (exp_apb_q.size() == 0) check("apb_unexpected", 1, 0);
                    else check("apb_request", {SWRT, SLV_IDX, SADDR, (SWRT ? SWDATA : 32'h0)},
                               exp_apb_q.pop_front());
                end
                2'd1: begin
                    APB_STATE = 2'd2;
                    wcnt = apb_waits;
                    set_cpl(wcnt == 0);
                end
                default: begin
                    if (PREADY) begin
                        APB_STATE = 2'd0;
                        set_cpl(1'b0);
                    end else begin
                        wcnt--;
                        set_cpl(wcnt == 0);
                    end
                end
            endcase
            streq_s = STREQ;
        end
    end

    // Driver tasks: call at posedge+1; each returns at posedge+1 after its handshake edge.
    task automatic drive_aw(input logic [31:0] a);
        AWADDR = a;
        AWVALID = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge PCLK);
            if (AWREADY) begin
                @(posedge PCLK);
                #1 AWVALID = 1'b0;
                return;
            end
        end
        AWVALID = 1'b0;
        check("aw_handshake_timeout", 0, 1);
    endtask

    task automatic drive_w(input logic [31:0] d, input logic [3:0] s);
        WDATA = d;
        WSTRB = s;
        WVALID = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge PCLK);
            if (WREADY) begin
                @(posedge PCLK);
                #1 WVALID = 1'b0;
                return;
            end
        end
        WVALID = 1'b0;
        check("w_handshake_timeout", 0, 1);
    endtask

    task automatic drive_ar(input logic [31:0] a);
        ARADDR = a;
        ARVALID = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge PCLK);
            if (ARREADY) begin
                @(posedge PCLK);
                #1 ARVALID = 1'b0;
                return;
            end
        end
        ARVALID = 1'b0;
        check("ar_handshake_timeout", 0, 1);
    endtask

    task automatic drive_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        fork
            drive_aw(a);
            drive_w(d, s);
        join
    endtask

    task automatic wait_idle(input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge PCLK);
            if (exp_apb_q.size() == 0 && exp_b_q.size() == 0 && exp_r_q.size() == 0 &&
                dbg_state == ST_IDLE) begin
                @(posedge PCLK);
                #1;
                return;
            end
        end
        check("idle_timeout", 0, 1);
        exp_apb_q.delete();
        exp_b_q.delete();
        exp_r_q.delete();
    endtask

    task automatic reset_dut();
        @(posedge PCLK);
        #1 PRESETn = 1'b0;
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1'b1;
    endtask

    initial begin
        PRESETn = 1'b0;
        AWVALID = 1'b0; AWADDR = '0;
        WVALID  = 1'b0; WDATA  = '0; WSTRB = 4'hF;
        ARVALID = 1'b0; ARADDR = '0;
        BREADY  = 1'b1; RREADY = 1'b1;

        // Reset values
        #12;
        check("rst_ready", {AWREADY, WREADY, ARREADY}, 3'b000);
        check("rst_ctrl", {BVALID, RVALID, STREQ, SSEL, SWRT, BRESP, RRESP, SLV_IDX, dbg_state}, 0);
        check("rst_data", {RDATA, SADDR, SWDATA}, 0);
        @(posedge PCLK);
        #1 PRESETn = 1'b1;
        @(negedge PCLK);
        check("rel_ready", {AWREADY, WREADY, ARREADY}, 3'b111);
        @(posedge PCLK);
        #1;

        // Zero-wait write, cycle by cycle
        exp_apb_q.push_back({1'b1, 4'd0, 32'h10, 32'hDEAD_BEEF});
        exp_b_q.push_back(2'b00);
        drive_wr(32'h10, 32'hDEAD_BEEF, 4'hF);
        @(negedge PCLK); check("wr_c1_state", dbg_state, ST_IDLE);
        @(negedge PCLK); check("wr_c2_streq_ssel", {STREQ, SSEL}, 2'b11);
        @(negedge PCLK); check("wr_c3_streq", STREQ, 1);
        @(negedge PCLK); check("wr_c4_streq", STREQ, 0);
        @(negedge PCLK); check("wr_c5_bvalid_ssel", {BVALID, SSEL, BRESP}, 4'b1000);
        wait_idle(20);

        // Read with 3 Access wait cycles
        apb_waits = 3;
        exp_apb_q.push_back({1'b0, 4'd0, 32'h4, 32'h0});
        exp_r_q.push_back({2'b00, 32'h1234_5678});
        drive_ar(32'h4);
        for (int k = 1; k <= 8; k++) begin
            @(negedge PCLK);
            check($sformatf("rd_rvalid_c%0d", k), RVALID, (k == 8));
        end
        wait_idle(20);
        apb_waits = 0;

        // W ahead of AW, slave error
        apb_err = 1'b1;
        x0 = n_xfer;
        exp_apb_q.push_back({1'b1, 4'd0, 32'h20, 32'hCAFE_F00D});
        exp_b_q.push_back(2'b10);
        drive_w(32'hCAFE_F00D, 4'hF);
        repeat (2) @(posedge PCLK);
        #1;
        drive_aw(32'h20);
        wait_idle(30);
        check("slverr_xfer_count", n_xfer - x0, 1);
        apb_err = 1'b0;

        // Decode error on a read: slave index 3 with two slaves
        x0 = n_xfer;
        exp_r_q.push_back({2'b11, 32'h0});
        drive_ar(32'h3000);
        @(negedge PCLK); check("dec_c1_ssel", {SSEL, STREQ}, 2'b00);
        @(negedge PCLK); check("dec_c2_rvalid_ssel", {RVALID, SSEL}, 2'b10);
        wait_idle(20);
        check("dec_xfer_count", n_xfer - x0, 0);

        // Write/read ready together twice: order W R W R at 5 cycles each
        reset_dut();
        hs_q.delete();
        exp_apb_q.push_back({1'b1, 4'd0, 32'h0100, 32'h1111_1111});
        exp_apb_q.push_back({1'b0, 4'd0, 32'h0200, 32'h0});
        exp_apb_q.push_back({1'b1, 4'd1, 32'h1104, 32'h2222_2222});
        exp_apb_q.push_back({1'b0, 4'd1, 32'h1208, 32'h0});
        exp_b_q.push_back(2'b00);
        exp_b_q.push_back(2'b00);
        exp_r_q.push_back({2'b00, rdata_of(32'h0200)});
        exp_r_q.push_back({2'b00, rdata_of(32'h1208)});
        fork
            begin
                drive_wr(32'h0100, 32'h1111_1111, 4'hF);
                drive_wr(32'h1104, 32'h2222_2222, 4'hF);
            end
            begin
                drive_ar(32'h0200);
                drive_ar(32'h1208);
            end
        join
        wait_idle(60);
        check("arb_hs_count", hs_q.size(), 4);
        for (int i = 1; i < hs_q.size(); i++)
            check($sformatf("arb_period_%0d", i), hs_q[i] - hs_q[i-1], 5);

        // RREADY held low: response stays stable and the pending write waits
        RREADY = 1'b0;
        exp_apb_q.push_back({1'b0, 4'd1, 32'h1008, 32'h0});
        exp_apb_q.push_back({1'b1, 4'd0, 32'h000C, 32'h3333_3333});
        exp_r_q.push_back({2'b00, rdata_of(32'h1008)});
        exp_b_q.push_back(2'b00);
        drive_ar(32'h1008);
        drive_wr(32'h000C, 32'h3333_3333, 4'hF);
        for (int i = 0; i < 30 && !RVALID; i++) @(negedge PCLK);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("stall_%0d", i), {RVALID, STREQ, RDATA}, {1'b1, 1'b0, rdata_of(32'h1008)});
            @(negedge PCLK);
        end
        @(posedge PCLK);
        #1 RREADY = 1'b1;
        wait_idle(40);

        // Reset during WAIT drops the transfer and its response
        apb_waits = 6;
        exp_apb_q.push_back({1'b1, 4'd1, 32'h1040, 32'h4444_4444});
        drive_wr(32'h1040, 32'h4444_4444, 4'hF);
        for (int i = 0; i < 20 && dbg_state != ST_WAIT; i++) @(negedge PCLK);
        check("mid_in_wait", dbg_state, ST_WAIT);
        #1 PRESETn = 1'b0;
        #1;
        check("mid_rst_ctrl", {AWREADY, BVALID, RVALID, STREQ, SSEL, SWRT, SLV_IDX, dbg_state}, 0);
        check("mid_rst_data", {SADDR, SWDATA, RDATA}, 0);
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        apb_waits = 0;
        @(negedge PCLK);
        check("mid_rel_ready", {AWREADY, WREADY, ARREADY}, 3'b111);
        repeat (10) @(negedge PCLK);
        check("mid_no_resp", {BVALID, RVALID}, 2'b00);
        @(posedge PCLK);
        #1;

        // Partial strobe
        x0 = n_xfer;
`ifdef AXI2APB_STRB_CHK_EN
        exp_b_q.push_back(2'b10);
        drive_wr(32'h30, 32'h55AA_55AA, 4'h3);
        @(negedge PCLK); check("strb_c1", {STREQ, BVALID}, 2'b00);
        @(negedge PCLK); check("strb_c2", {BVALID, STREQ, SSEL}, 3'b100);
        wait_idle(20);
        check("strb_xfer_count", n_xfer - x0, 0);
`else
        exp_apb_q.push_back({1'b1, 4'd0, 32'h30, 32'h55AA_55AA});
        exp_b_q.push_back(2'b00);
        drive_wr(32'h30, 32'h55AA_55AA, 4'h3);
        wait_idle(20);
        check("strb_xfer_count", n_xfer - x0, 1);
`endif

        check("streq_during_access", streq_in_access, 0);
        check("queues_drained", exp_apb_q.size() + exp_b_q.size() + exp_r_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
